// File: rtl/ntt_radix8_pipe.sv
// Pipelined radix-8 NTT butterfly engine: psi pre-weighting stage followed by three
// mod-Q butterfly stages, valid/ready flow control with a global advance enable.

module ntt_psi_mul #(
    parameter int WIDTH = 18,
    parameter int Q     = 12289
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] psi,
    input  logic             psi_en,
    output logic [WIDTH-1:0] y
);
    localparam logic [WIDTH-1:0]   QN = WIDTH'(Q);
    localparam logic [2*WIDTH-1:0] QW = (2*WIDTH)'(Q);

    logic [WIDTH-1:0]   xm;
    logic [WIDTH-1:0]   pm;
    logic [2*WIDTH-1:0] prod;

    always_comb begin
        xm   = x % QN;
        pm   = psi_en ? (psi % QN) : WIDTH'(1);
        prod = {{WIDTH{1'b0}}, xm} * {{WIDTH{1'b0}}, pm};
        y    = WIDTH'(prod % QW);
    end
endmodule

module ntt_bf #(
    parameter int WIDTH = 18,
    parameter int Q     = 12289
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] t,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam logic [2*WIDTH-1:0] QW = (2*WIDTH)'(Q);
    localparam logic [WIDTH:0]     QS = (WIDTH+1)'(Q);

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   p;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     dif;

    // a and p are both < Q, so one conditional correction suffices on each side
    always_comb begin
        prod = {{WIDTH{1'b0}}, b} * {{WIDTH{1'b0}}, t};
        p    = WIDTH'(prod % QW);
        sum  = {1'b0, a} + {1'b0, p};
        hi   = (sum >= QS) ? WIDTH'(sum - QS) : WIDTH'(sum);
        dif  = (a < p) ? ({1'b0, a} + QS - {1'b0, p}) : ({1'b0, a} - {1'b0, p});
        lo   = WIDTH'(dif);
    end
endmodule

module ntt_radix8_pipe #(
    parameter int WIDTH = 18,
    parameter int Q     = 12289,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [8*WIDTH-1:0] in_data,
    input  logic [8*WIDTH-1:0] psi,
    input  logic               psi_en,
    input  logic [4*WIDTH-1:0] w,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [8*WIDTH-1:0] out_data,
    output logic [TAG_W-1:0]   out_tag
);
    localparam int STAGES = 4;

    typedef logic [7:0][WIDTH-1:0] lanes_t;
    typedef logic [3:0][WIDTH-1:0] tw_t;

    logic [STAGES:1]  vld_pipe;
    logic             adv;
    lanes_t           in_lanes, psi_lanes;
    lanes_t           d1, d2, d3, d4;
    lanes_t           r1, r2, r3, r4;
    tw_t              w1, w2, w3;
    logic [TAG_W-1:0] tag1, tag2, tag3, tag4;

    // Whole pipe moves as one; it only freezes when the output slot is occupied and blocked
    assign adv       = !vld_pipe[STAGES] || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_pipe[STAGES];
    assign out_data  = r4;
    assign out_tag   = tag4;
    assign in_lanes  = in_data;
    assign psi_lanes = psi;

    genvar k;
    generate
        for (k = 0; k < 8; k++) begin : g_psi
            ntt_psi_mul #(.WIDTH(WIDTH), .Q(Q)) u_mul (
                .x      (in_lanes[k]),
                .psi    (psi_lanes[k]),
                .psi_en (psi_en),
                .y      (d1[k])
            );
        end

        for (k = 0; k < 4; k++) begin : g_bf
            localparam int I0 = 2 * k;
            localparam int I1 = (k / 2) * 4 + (k % 2);
            localparam int I2 = k;

            ntt_bf #(.WIDTH(WIDTH), .Q(Q)) u_s0 (
                .a  (r1[I0]),
                .b  (r1[I0+1]),
                .t  (WIDTH'(1)),
                .hi (d2[I0]),
                .lo (d2[I0+1])
            );

            // odd pairs in the span-2 stage use w_2, even pairs w_0
            ntt_bf #(.WIDTH(WIDTH), .Q(Q)) u_s1 (
                .a  (r2[I1]),
                .b  (r2[I1+2]),
                .t  (w2[2*(k%2)]),
                .hi (d3[I1]),
                .lo (d3[I1+2])
            );

            ntt_bf #(.WIDTH(WIDTH), .Q(Q)) u_s2 (
                .a  (r3[I2]),
                .b  (r3[I2+4]),
                .t  (w3[k]),
                .hi (d4[I2]),
                .lo (d4[I2+4])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            r1       <= '0;
            r2       <= '0;
            r3       <= '0;
            r4       <= '0;
            w1       <= '0;
            w2       <= '0;
            w3       <= '0;
            tag1     <= '0;
            tag2     <= '0;
            tag3     <= '0;
            tag4     <= '0;
        end else if (adv) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
            r1       <= d1;
            w1       <= w;
            tag1     <= in_tag;
            r2       <= d2;
            w2       <= w1;
            tag2     <= tag1;
            r3       <= d3;
            w3       <= w2;
            tag3     <= tag2;
            r4       <= d4;
            tag4     <= tag3;
        end
    end
endmodule

// File: tb/tb_ntt_radix8_pipe.sv
// Directed and streaming checks for ntt_radix8_pipe against hand-computed vectors
// and a direct-sum 8-point NTT model.

module tb_ntt_radix8_pipe;
    localparam int W  = 18;
    localparam int Q  = 12289;
    localparam int TW = 4;

    typedef logic [7:0][W-1:0] lanes_t;
    typedef logic [3:0][W-1:0] tw_t;
    typedef struct {
        lanes_t x;
        lanes_t ps;
        logic   pe;
        tw_t    wv;
        lanes_t exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    lanes_t        in_data = '0;
    lanes_t        psi = '0;
    logic          psi_en = 1'b0;
    tw_t           w = '0;
    logic [TW-1:0] in_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    lanes_t        out_data;
    logic [TW-1:0] out_tag;

    int checks = 0;
    int errors = 0;

    ntt_radix8_pipe #(.WIDTH(W), .Q(Q), .TAG_W(TW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .psi       (psi),
        .psi_en    (psi_en),
        .w         (w),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input lanes_t act, input lanes_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic lanes_t splat(int v);
        lanes_t r;
        for (int i = 0; i < 8; i++) r[i] = W'(v);
        return r;
    endfunction

    function automatic lanes_t one_hot(int k, int v);
        lanes_t r = '0;
        r[k] = W'(v);
        return r;
    endfunction

    function automatic longint powmod(longint b, int e);
        longint r = 1;
        for (int i = 0; i < e; i++) r = (r * b) % Q;
        return r;
    endfunction

    // 1479 squares to -1 mod 12289 (a 4th root), so derive a genuine primitive 8th root
    function automatic longint find_omega();
        longint r;
        for (longint g = 2; g < 200; g++) begin
            r = powmod(g, (Q - 1) / 8);
            if (powmod(r, 4) == Q - 1) return r;
        end
        return 1;
    endfunction

    function automatic int bitrev3(int n);
        return ((n & 1) << 2) | (n & 2) | ((n >> 2) & 1);
    endfunction

    // X[k] = sum_n x_nat[n] * om^(n*k); input lanes hold x_nat in bit-reversed order
    function automatic lanes_t golden(lanes_t x, longint om);
        lanes_t r;
        longint acc;
        for (int k = 0; k < 8; k++) begin
            acc = 0;
            for (int n = 0; n < 8; n++)
                acc = (acc + (longint'(x[bitrev3(n)]) % Q) * powmod(om, (n * k) % 8)) % Q;
            r[k] = W'(acc);
        end
        return r;
    endfunction

    vec_t vecs[6];

    initial begin
        lanes_t        alt, snap_d, xr, exq[$];
        logic [TW-1:0] snap_t, tgq[$];
        tw_t           tw1, twr;
        longint        om;
        int            c, sent, rx, extra;

        tw1 = {4{W'(1)}};
        for (int i = 0; i < 8; i++) alt[i] = (i % 2 == 1) ? W'(Q - 1) : W'(1);
        vecs[0] = '{x: splat(1),          ps: '0,               pe: 1'b0, wv: tw1, exp: one_hot(0, 8)};
        vecs[1] = '{x: one_hot(1, 1),     ps: '0,               pe: 1'b0, wv: tw1, exp: alt};
        vecs[2] = '{x: one_hot(0, 5),     ps: one_hot(0, 2),    pe: 1'b1, wv: tw1, exp: splat(10)};
        vecs[3] = '{x: one_hot(0, 5),     ps: one_hot(0, 2),    pe: 1'b0, wv: tw1, exp: splat(5)};
        vecs[4] = '{x: one_hot(0, Q + 3), ps: '0,               pe: 1'b0, wv: tw1, exp: splat(3)};
        vecs[5] = '{x: one_hot(0, Q - 1), ps: one_hot(0, Q + 2), pe: 1'b1, wv: tw1, exp: splat(Q - 2)};

        // reset state
        repeat (2) @(negedge clk);
        chk("reset out_valid", lanes_t'(out_valid), lanes_t'(0));
        chk("reset out_data", out_data, lanes_t'(0));
        chk("reset out_tag", lanes_t'(out_tag), lanes_t'(0));
        rst_n = 1'b1;
        #1;
        chk("in_ready after reset", lanes_t'(in_ready), lanes_t'(1));

        // single transforms from the table, inputs scrambled right after accept
        for (int v = 0; v < 6; v++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = 1'b1;
            in_data   = vecs[v].x;
            psi       = vecs[v].ps;
            psi_en    = vecs[v].pe;
            w         = vecs[v].wv;
            in_tag    = TW'(v + 3);
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = splat(777);
            psi      = splat(3);
            psi_en   = ~psi_en;
            w        = '1;
            in_tag   = '1;
            c = 1;
            while (!out_valid && c < 10) begin
                @(negedge clk);
                c++;
            end
            chk($sformatf("vec%0d latency", v), lanes_t'(c), lanes_t'(4));
            chk($sformatf("vec%0d data", v), out_data, vecs[v].exp);
            chk($sformatf("vec%0d tag", v), lanes_t'(out_tag), lanes_t'(v + 3));
        end

        // back-to-back stream of 10 with a 3-cycle output hold
        @(negedge clk);
        sent = 0;
        rx   = 0;
        for (int cyc = 0; cyc < 40 && rx < 10; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 6 && cyc < 9);
            in_valid  = (sent < 10);
            in_tag    = TW'(sent);
            in_data   = one_hot(0, sent + 1);
            psi_en    = 1'b0;
            w         = tw1;
            #1;
            if (cyc == 6) begin
                snap_d = out_data;
                snap_t = out_tag;
            end
            if (cyc >= 6 && cyc < 9) begin
                chk($sformatf("hold in_ready c%0d", cyc), lanes_t'(in_ready), lanes_t'(0));
                chk($sformatf("hold out_valid c%0d", cyc), lanes_t'(out_valid), lanes_t'(1));
                if (cyc > 6) begin
                    chk($sformatf("hold data c%0d", cyc), out_data, snap_d);
                    chk($sformatf("hold tag c%0d", cyc), lanes_t'(out_tag), lanes_t'(snap_t));
                end
            end
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                chk($sformatf("stream tag %0d", rx), lanes_t'(out_tag), lanes_t'(rx));
                chk($sformatf("stream data %0d", rx), out_data, splat(rx + 1));
                rx++;
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        chk("stream count", lanes_t'(rx), lanes_t'(10));
        chk("stream no duplicates", lanes_t'(extra), lanes_t'(0));

        // random vectors with real twiddles, random stalls and bubbles
        om = find_omega();
        for (int j = 0; j < 4; j++) twr[j] = W'(powmod(om, j));
        sent = 0;
        rx   = 0;
        for (int cyc = 0; cyc < 8000 && rx < 1000; cyc++) begin
            @(negedge clk);
            out_ready = ($urandom_range(3) != 0);
            for (int i = 0; i < 8; i++) xr[i] = W'($urandom_range(Q - 1));
            in_valid = (sent < 1000) && ($urandom_range(4) != 0);
            in_data  = xr;
            psi      = splat(5);
            psi_en   = 1'b0;
            w        = twr;
            in_tag   = TW'(sent);
            #1;
            if (out_valid && out_ready) begin
                if (exq.size() == 0) begin
                    chk("ntt unexpected output", lanes_t'(1), lanes_t'(0));
                end else begin
                    chk($sformatf("ntt data %0d", rx), out_data, exq.pop_front());
                    chk($sformatf("ntt tag %0d", rx), lanes_t'(out_tag), lanes_t'(tgq.pop_front()));
                end
                rx++;
            end
            if (in_valid && in_ready) begin
                exq.push_back(golden(xr, om));
                tgq.push_back(TW'(sent));
                sent++;
            end
        end
        chk("ntt count", lanes_t'(rx), lanes_t'(1000));

        // reset while stalled with three transforms in flight
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(negedge clk);
        out_ready = 1'b0;
        w = tw1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_tag   = TW'(i + 1);
            in_data  = one_hot(0, i + 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        c = 0;
        while (!out_valid && c < 10) begin
            @(negedge clk);
            c++;
        end
        chk("stall in_ready", lanes_t'(in_ready), lanes_t'(0));
        chk("stall head tag", lanes_t'(out_tag), lanes_t'(1));
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid-stall reset out_valid", lanes_t'(out_valid), lanes_t'(0));
        chk("mid-stall reset out_data", out_data, lanes_t'(0));
        chk("mid-stall reset out_tag", lanes_t'(out_tag), lanes_t'(0));
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("mid-stall reset in_ready", lanes_t'(in_ready), lanes_t'(1));
        extra = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        chk("no stale after reset", lanes_t'(extra), lanes_t'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
